// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: clk_out = clk/N, N in [2, 2^DIV_W-1].
// Define CLKDIV_DUTY50_EN to add the negedge extension that gives odd N an exact 50% duty.
`timescale 1ns/1ps

module clk_div_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid,
  output logic             div_ready,
  output logic [DIV_W-1:0] cur_div,
  output logic             running,
  output logic             tick,
  output logic             clk_out
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             out_p_q, out_p_d;
  logic             tick_q, tick_d;

  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] cnt_nxt;
  logic             last;
  logic             apply;

  function automatic logic [DIV_W-1:0] clamp(input logic [DIV_W-1:0] x);
    return (x < DIV_W'(2)) ? DIV_W'(2) : x;
  endfunction

  assign half    = cur_div_q >> 1;
  assign cnt_nxt = cnt_q + DIV_W'(1);
  assign last    = (cnt_q == cur_div_q - DIV_W'(1));
  // A pending divisor lands only where it cannot shorten a period: idle, or the wrap edge.
  assign apply   = pend_valid_q && ((state_q == S_IDLE) || last);

  always_comb begin
    // NOTE: every signal gets a default before any branch, otherwise a missed path infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_div_d    = cur_div_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    out_p_d      = out_p_q;
    tick_d       = 1'b0;

    // Accept and apply are mutually exclusive, so a same-edge accept waits for the next apply point.
    if (div_valid && !pend_valid_q) begin
      pend_d       = div_i;
      pend_valid_d = 1'b1;
    end
    if (apply) begin
      cur_div_d    = clamp(pend_q);
      pend_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_RUN;
          cnt_d   = '0;
          out_p_d = 1'b1;
          tick_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (!last) begin
          cnt_d   = cnt_nxt;
          out_p_d = (cnt_nxt < half);
        end else if (en) begin
          cnt_d   = '0;
          out_p_d = 1'b1;
          tick_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
          out_p_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cur_div_q    <= DEF_DIV;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      out_p_q      <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      out_p_q      <= out_p_d;
      tick_q       <= tick_d;
    end
  end

`ifdef CLKDIV_DUTY50_EN
  logic out_n_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) out_n_q <= 1'b0;
    else     out_n_q <= out_p_q;
  end

  // out_n trails out_p by half a cycle on both edges, so the OR of flops cannot glitch.
  assign clk_out = out_p_q | (out_n_q & cur_div_q[0]);
`else
  assign clk_out = out_p_q;
`endif

  assign div_ready = !pend_valid_q;
  assign cur_div   = cur_div_q;
  assign running   = (state_q == S_RUN);
  assign tick      = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog: reset, even/odd divide, updates, clamp, en drop.
`timescale 1ns/1ps

module tb_clk_div_prog;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div_i;
  logic             div_valid;
  logic             div_ready;
  logic [DIV_W-1:0] cur_div;
  logic             running;
  logic             tick;
  logic             clk_out;

  int tests = 0;
  int fails = 0;

  clk_div_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_i     (div_i),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .cur_div   (cur_div),
    .running   (running),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_i = '0; div_valid = 1'b0;
    #1;
    check("rst_clk_out", clk_out, 0);
    check("rst_running", running, 0);
    check("rst_tick", tick, 0);
    check("rst_cur_div", cur_div, 5);
    check("rst_div_ready", div_ready, 1);
    step(2);
    rst = 1'b0;

    // Idle load of N=4: accept on one edge, applied on the next.
    div_i = 8'd4; div_valid = 1'b1;
    step(1);
    div_valid = 1'b0;
    check("idle_pend_ready", div_ready, 0);
    check("idle_pend_cur", cur_div, 5);
    step(1);
    check("idle_load_cur", cur_div, 4);
    check("idle_load_ready", div_ready, 1);
    check("idle_running", running, 0);

    // Even divide N=4: high 2, low 2, tick on each rise, rise on the edge sampling en.
    en = 1'b1;
    step(1);
    check("start_running", running, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("n4_clk_%0d", i), clk_out, ((i % 4) < 2) ? 1 : 0);
      check($sformatf("n4_tick_%0d", i), tick, ((i % 4) == 0) ? 1 : 0);
      step(1);
    end

    // Mid-period update to 6 while cnt=1: current period stays 4.
    step(1);
    div_i = 8'd6; div_valid = 1'b1;
    step(1);
    div_valid = 1'b0;
    check("upd_ready_lo_a", div_ready, 0);
    check("upd_cur_old_a", cur_div, 4);
    check("upd_clk_cnt2", clk_out, 0);
    step(1);
    check("upd_ready_lo_b", div_ready, 0);
    check("upd_cur_old_b", cur_div, 4);
    step(1);
    check("upd_cur_new", cur_div, 6);
    check("upd_ready_hi", div_ready, 1);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("n6_clk_%0d", i), clk_out, ((i % 6) < 3) ? 1 : 0);
      check($sformatf("n6_tick_%0d", i), tick, ((i % 6) == 0) ? 1 : 0);
      step(1);
    end

    // en drop at cnt=2: period completes, then idle with no tick.
    step(2);
    en = 1'b0;
    check("drop_clk_cnt2", clk_out, 1);
    for (int i = 3; i < 6; i++) begin
      step(1);
      check($sformatf("drop_run_cnt%0d", i), running, 1);
      check($sformatf("drop_tick_cnt%0d", i), tick, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1);
      check($sformatf("drop_idle_run_%0d", i), running, 0);
      check($sformatf("drop_idle_clk_%0d", i), clk_out, 0);
      check($sformatf("drop_idle_tick_%0d", i), tick, 0);
    end
    en = 1'b1;
    step(1);
    check("restart_tick", tick, 1);
    check("restart_clk", clk_out, 1);
    step(1);
    check("restart_cnt1_clk", clk_out, 1);
    check("restart_cnt1_tick", tick, 0);
    en = 1'b0;
    step(5);
    check("restart_stop", running, 0);

    // Clamp: a requested divisor of 1 loads as 2.
    div_i = 8'd1; div_valid = 1'b1;
    step(1);
    div_valid = 1'b0;
    check("clamp_pend_cur", cur_div, 6);
    step(1);
    check("clamp_cur", cur_div, 2);
    check("clamp_ready", div_ready, 1);
    en = 1'b1;
    step(1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("n2_clk_%0d", i), clk_out, ((i % 2) == 0) ? 1 : 0);
      check($sformatf("n2_tick_%0d", i), tick, ((i % 2) == 0) ? 1 : 0);
      step(1);
    end

    // Load 5 while running N=2 with en dropped: applied on the stopping wrap edge.
    en = 1'b0; div_i = 8'd5; div_valid = 1'b1;
    step(1);
    div_valid = 1'b0;
    check("n5_pend_run", running, 1);
    step(1);
    check("n5_stop_run", running, 0);
    check("n5_cur", cur_div, 5);

    // Odd divide N=5, sampled after the posedge and after the negedge.
    en = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) begin
`ifdef CLKDIV_DUTY50_EN
      check($sformatf("n5_pos_%0d", i), clk_out, ((i % 5) < 3) ? 1 : 0);
`else
      check($sformatf("n5_pos_%0d", i), clk_out, ((i % 5) < 2) ? 1 : 0);
`endif
      check($sformatf("n5_tick_%0d", i), tick, ((i % 5) == 0) ? 1 : 0);
      #5;
      check($sformatf("n5_neg_%0d", i), clk_out, ((i % 5) < 2) ? 1 : 0);
      @(posedge clk);
      #1;
    end

    // Async reset mid-period with a divisor pending.
    div_i = 8'd9; div_valid = 1'b1;
    step(1);
    div_valid = 1'b0;
    check("pre_rst_ready", div_ready, 0);
    check("pre_rst_clk", clk_out, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_clk", clk_out, 0);
    check("mid_rst_running", running, 0);
    check("mid_rst_tick", tick, 0);
    check("mid_rst_ready", div_ready, 1);
    check("mid_rst_cur", cur_div, 5);
    step(1);
    check("hold_rst_clk", clk_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
